// File: rtl/word_xform_fifo.sv
// word_xform_fifo: per-word transform (pass / invert / bit-reverse / popcount)
// feeding a DEPTH-entry output FIFO, with a running count of accepted words.
//
// Handshake rules (both sides): a transfer happens at a rising edge where
// valid && ready are both high. in_ready depends only on registered level, so
// there is no combinational path from out_ready to in_ready. A full FIFO
// never accepts, even when a pop happens in the same cycle. out_ready while
// empty is ignored.
module word_xform_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           word_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_REV  = 2'd2;
  localparam logic [1:0] MODE_POP  = 2'd3;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] xform_d;
  logic             push, pop;

  assign in_ready   = (level_q < LW'(DEPTH));
  assign out_valid  = (level_q != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_data   = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign word_count = count_q;

  // Transform the offered word according to its mode; only used on accept.
  always_comb begin
    xform_d = '0;
    unique case (in_mode)
      MODE_PASS: xform_d = in_data;
      MODE_INV:  xform_d = ~in_data;
      MODE_REV: begin
        for (int i = 0; i < WIDTH; i++) xform_d[i] = in_data[WIDTH-1-i];
      end
      MODE_POP: begin
        // The count fits in WIDTH bits for WIDTH >= 2, so a WIDTH-wide sum is exact.
        for (int i = 0; i < WIDTH; i++) xform_d = xform_d + WIDTH'(in_data[i]);
      end
      default: xform_d = in_data;
    endcase
  end

  // Next-state for pointers, occupancy and accepted-word counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      count_d  = count_q + CNT_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state register; reset empties the queue and clears the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      count_q  <= count_d;
    end
  end

  // Storage array: written on accept, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= xform_d;
  end

endmodule
